// File: rtl/i2c_master_ctrl_pkg.sv
// rtl/i2c_master_ctrl_pkg.sv - shared I2C master state codes and output decode helpers
package i2c_master_ctrl_pkg;

    // State codes shared with the master datapath; values are part of the interface.
    typedef enum logic [7:0] {
        IDLE       = 8'h00,
        START      = 8'h01,
        ADDRESS    = 8'h02,
        READ_ACK   = 8'h03,
        WRITE_DATA = 8'h04,
        READ_ACK2  = 8'h05,
        READ_DATA  = 8'h06,
        WRITE_ACK2 = 8'h07,
        STOP       = 8'h08
    } state_t;

    // First bit index of every byte (MSB first).
    localparam logic [3:0] BIT_MSB = 4'd7;

    // SCL is held high while the bus is idle and around START/STOP conditions.
    function automatic logic scl_release(input state_t st);
        return (st == IDLE) || (st == START) || (st == STOP);
    endfunction

    // The master owns SDA everywhere except where the slave drives data or ACK.
    function automatic logic sda_drive(input state_t st);
        return (st == START) || (st == ADDRESS) || (st == WRITE_DATA) ||
               (st == WRITE_ACK2) || (st == STOP);
    endfunction

endpackage

// File: rtl/i2c_master_ctrl.sv
// rtl/i2c_master_ctrl.sv - I2C master control FSM (optional burst via I2C_BURST_EN)
module i2c_master_ctrl
    import i2c_master_ctrl_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic       i2c_scl_in,
    input  logic       resetN,
    input  logic       enable,
    input  logic       rw,
    input  logic       SDA_in,
    output logic [7:0] state,
    output logic [3:0] count,
    output logic       i2c_scl_en,
    output logic       i2c_write_en,
    output logic       ready,
    output logic       done,
    output logic       ack_error
`ifdef I2C_BURST_EN
    ,
    output logic       ack_bit
`endif
);

    state_t     r_state;
    logic [3:0] r_count;
    logic       r_rw;
    logic       r_scl_en;
    logic       r_write_en;
    logic       r_done;
    logic       r_ack_error;

    state_t     w_next_state;
    logic [3:0] w_next_count;
    logic       w_next_rw;
    logic       w_next_ack_error;

`ifdef I2C_BURST_EN
    localparam logic [3:0] BURST_LIMIT = 4'(BURST_MAX);

    logic [3:0] r_bytes;
    logic [3:0] w_next_bytes;
    logic       w_burst_more;
`endif

    // Next-state, bit index, direction and error flag for the coming SCL edge.
    always_comb begin
        w_next_state     = r_state;
        w_next_count     = r_count;
        w_next_rw        = r_rw;
        w_next_ack_error = r_ack_error;
`ifdef I2C_BURST_EN
        w_next_bytes     = r_bytes;
        w_burst_more     = enable && (r_bytes < BURST_LIMIT);
`endif
        case (r_state)
            IDLE: begin
                if (enable) begin
                    w_next_rw    = rw;
                    w_next_state = START;
                end
            end
            START: begin
                w_next_count     = BIT_MSB;
                w_next_ack_error = 1'b0;
`ifdef I2C_BURST_EN
                w_next_bytes     = 4'd0;
`endif
                w_next_state     = ADDRESS;
            end
            ADDRESS: begin
                if (r_count == 4'd0) begin
                    w_next_state = READ_ACK;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            READ_ACK: begin
                if (SDA_in) begin
                    w_next_ack_error = 1'b1;
                    w_next_state     = STOP;
                end else begin
                    w_next_count = BIT_MSB;
                    w_next_state = r_rw ? READ_DATA : WRITE_DATA;
                end
            end
            WRITE_DATA: begin
                if (r_count == 4'd0) begin
`ifdef I2C_BURST_EN
                    w_next_bytes = r_bytes + 4'd1;
`endif
                    w_next_state = READ_ACK2;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            READ_ACK2: begin
                if (SDA_in) begin
                    w_next_ack_error = 1'b1;
                    w_next_state     = STOP;
`ifdef I2C_BURST_EN
                end else if (w_burst_more) begin
                    w_next_count = BIT_MSB;
                    w_next_state = WRITE_DATA;
`endif
                end else begin
                    w_next_state = STOP;
                end
            end
            READ_DATA: begin
                if (r_count == 4'd0) begin
`ifdef I2C_BURST_EN
                    w_next_bytes = r_bytes + 4'd1;
`endif
                    w_next_state = WRITE_ACK2;
                end else begin
                    w_next_count = r_count - 4'd1;
                end
            end
            WRITE_ACK2: begin
`ifdef I2C_BURST_EN
                if (w_burst_more) begin
                    w_next_count = BIT_MSB;
                    w_next_state = READ_DATA;
                end else begin
                    w_next_state = STOP;
                end
`else
                w_next_state = STOP;
`endif
            end
            STOP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // State register; SCL/SDA enables are decoded from the next state so they change with it.
    always_ff @(posedge i2c_scl_in or posedge resetN) begin
        if (resetN) begin
            r_state     <= IDLE;
            r_count     <= 4'd0;
            r_rw        <= 1'b0;
            r_scl_en    <= 1'b1;
            r_write_en  <= 1'b0;
            r_done      <= 1'b0;
            r_ack_error <= 1'b0;
`ifdef I2C_BURST_EN
            r_bytes     <= 4'd0;
`endif
        end else begin
            r_state     <= w_next_state;
            r_count     <= w_next_count;
            r_rw        <= w_next_rw;
            r_scl_en    <= scl_release(w_next_state);
            r_write_en  <= sda_drive(w_next_state);
            r_done      <= (r_state == STOP);
            r_ack_error <= w_next_ack_error;
`ifdef I2C_BURST_EN
            r_bytes     <= w_next_bytes;
`endif
        end
    end

    assign state        = r_state;
    assign count        = r_count;
    assign i2c_scl_en   = r_scl_en;
    assign i2c_write_en = r_write_en;
    assign ready        = (r_state == IDLE) && !resetN;
    assign done         = r_done;
    assign ack_error    = r_ack_error;
`ifdef I2C_BURST_EN
    // Master ACK (0) only when another read byte follows; NACK ends the read.
    assign ack_bit      = !((r_state == WRITE_ACK2) && w_burst_more);
`endif

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// tb/tb_i2c_master_ctrl.sv - self-checking bench for i2c_master_ctrl
module tb_i2c_master_ctrl;

    localparam logic [7:0] S_IDLE = 8'h00, S_START = 8'h01, S_ADDRESS = 8'h02,
                           S_READ_ACK = 8'h03, S_WRITE_DATA = 8'h04, S_READ_ACK2 = 8'h05,
                           S_READ_DATA = 8'h06, S_WRITE_ACK2 = 8'h07, S_STOP = 8'h08;
`ifdef I2C_BURST_EN
    localparam int BURST_BYTES = 2;
`else
    localparam int BURST_BYTES = 1;
`endif

    logic       clk = 1'b0;
    logic       resetN, enable, rw, SDA_in;
    logic [7:0] state;
    logic [3:0] count;
    logic       i2c_scl_en, i2c_write_en, ready, done, ack_error;
`ifdef I2C_BURST_EN
    logic       ack_bit;
`endif

    i2c_master_ctrl #(.BURST_MAX(2)) dut (
        .i2c_scl_in   (clk),
        .resetN       (resetN),
        .enable       (enable),
        .rw           (rw),
        .SDA_in       (SDA_in),
        .state        (state),
        .count        (count),
        .i2c_scl_en   (i2c_scl_en),
        .i2c_write_en (i2c_write_en),
        .ready        (ready),
        .done         (done),
        .ack_error    (ack_error)
`ifdef I2C_BURST_EN
        ,
        .ack_bit      (ack_bit)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] st;
        logic [3:0] cnt;
        logic       err;
        logic       dn;
        logic       ab;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    logic m_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] st, input logic [3:0] c, input logic e,
                        input logic d, input logic ab);
        exp_t x;
        x.st = st; x.cnt = c; x.err = e; x.dn = d; x.ab = ab;
        q.push_back(x);
    endtask

    // Expected cycle-by-cycle trace of one transaction, from START to the IDLE/done cycle.
    task automatic model_txn(input logic rw_v, input logic sda_a, input logic sda_d, input int nb);
        push(S_START, 4'd0, m_err, 1'b0, 1'b1);
        m_err = 1'b0;
        for (int i = 7; i >= 0; i--) push(S_ADDRESS, 4'(i), 1'b0, 1'b0, 1'b1);
        push(S_READ_ACK, 4'd0, 1'b0, 1'b0, 1'b1);
        if (sda_a) begin
            m_err = 1'b1;
        end else begin
            for (int b = 0; b < nb; b++) begin
                for (int i = 7; i >= 0; i--)
                    push(rw_v ? S_READ_DATA : S_WRITE_DATA, 4'(i), 1'b0, 1'b0, 1'b1);
                if (rw_v) push(S_WRITE_ACK2, 4'd0, 1'b0, 1'b0, (b == nb - 1));
                else      push(S_READ_ACK2, 4'd0, 1'b0, 1'b0, 1'b1);
            end
            if (!rw_v && sda_d) m_err = 1'b1;
        end
        push(S_STOP, 4'd0, m_err, 1'b0, 1'b1);
        push(S_IDLE, 4'd0, m_err, 1'b1, 1'b1);
    endtask

    // Compare DUT outputs against the model trace, sampled mid high phase.
    always begin
        exp_t e;
        logic exp_scl, exp_we;
        @(posedge clk);
        #2;
        if (q.size() > 0) begin
            e = q.pop_front();
            exp_scl = (e.st == S_IDLE) || (e.st == S_START) || (e.st == S_STOP);
            exp_we  = (e.st == S_START) || (e.st == S_ADDRESS) || (e.st == S_WRITE_DATA) ||
                      (e.st == S_WRITE_ACK2) || (e.st == S_STOP);
            check("trace", {15'd0, state, count, i2c_scl_en, i2c_write_en, ready, done, ack_error},
                  {15'd0, e.st, e.cnt, exp_scl, exp_we, (e.st == S_IDLE), e.dn, e.err});
`ifdef I2C_BURST_EN
            check("ack_bit", {31'd0, ack_bit}, {31'd0, e.ab});
`endif
        end
    end

    task automatic run_txn(input logic rw_v, input logic sda_a, input logic sda_d,
                           input logic hold, input logic toggle, input int nb,
                           input int exp_lat, input logic exp_err);
        int   k;
        logic seen;
        @(negedge clk);
        model_txn(rw_v, sda_a, sda_d, nb);
        rw = rw_v; SDA_in = sda_a; enable = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < 80) begin
            @(negedge clk);
            k++;
            if (k == 1 && !hold) enable = 1'b0;
            if (k == 11) SDA_in = sda_d;
            if (toggle && k == 13) rw = ~rw_v;
            if (toggle && k == 15) rw = rw_v;
            if (toggle && k == 16) rw = ~rw_v;
            if (done) seen = 1'b1;
        end
        enable = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
            q.delete();
        end else begin
            check("latency", 32'(k), 32'(exp_lat));
        end
        @(negedge clk);
        check("after_done", {29'd0, state[2:0] == 3'd0, done, ack_error}, {29'd0, 1'b1, 1'b0, exp_err});
    endtask

    initial begin
        resetN = 1'b1; enable = 1'b0; rw = 1'b0; SDA_in = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_vals", {15'd0, state, count, i2c_scl_en, i2c_write_en, done, ack_error},
              {15'd0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        resetN = 1'b0;
        #2;
        check("ready_after_reset", {31'd0, ready}, 32'd1);

        // Reset mid-ADDRESS at count 3: aborts with no clock edge.
        @(negedge clk); rw = 1'b0; enable = 1'b1;
        @(negedge clk); enable = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_addr", {20'd0, state, count}, {20'd0, 8'h02, 4'd3});
        #1 resetN = 1'b1;
        #1;
        check("async_reset", {16'd0, state, count, i2c_scl_en, i2c_write_en, ready, done},
              {16'd0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0});
        @(negedge clk); resetN = 1'b0;
        #2;
        check("release_ready", {23'd0, state, ready}, {23'd0, 8'h00, 1'b1});

        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1, 21, 1'b0);   // write, ACK
        run_txn(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 21, 1'b0);   // read, ACK
        run_txn(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1, 12, 1'b1);   // address NACK
        run_txn(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 21, 1'b0);   // rw toggled mid-write
        run_txn(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 21, 1'b1);   // data NACK
        run_txn(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, BURST_BYTES, 21 + 9 * (BURST_BYTES - 1), 1'b0);
        run_txn(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, BURST_BYTES, 21 + 9 * (BURST_BYTES - 1), 1'b0);

        repeat (2) @(negedge clk);
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_master_ctrl.md
Name: i2c_master_ctrl

Overview:
- Control FSM for the I2C master, directly upstream of the master datapath.
- Produces the state code, bit index (count), SCL-release enable and SDA-drive enable that the datapath consumes.
- Samples slave ACK bits from SDA and sequences START, address, data and STOP for single-byte write/read transactions, with optional burst.
- Advances on posedge of i2c_scl_in; the datapath shifts on negedge, so every state/count value is stable for half a period before use.

Parameters:
- BURST_MAX, 4, maximum bytes per transaction when burst is compiled in; ignored otherwise. Legal range 1..15.

Ports:
- i2c_scl_in  input  1  I2C bit clock, posedge-active in this block.
- resetN  input  1  asynchronous, active-high reset. The name is kept for codebase consistency; asserted = 1.
- enable  input  1  transaction request, level. Sampled in IDLE; with burst, also in the ACK states.
- rw  input  1  direction for the next transaction: 0 = write, 1 = read. Sampled in IDLE only.
- SDA_in  input  1  bus SDA value, sampled in READ_ACK and READ_ACK2.
- state  output  8  current state code, from the shared constants.
- count  output  4  bit index for the datapath, 7..0.
- i2c_scl_en  output  1  1 = hold SCL high (bus idle/start/stop); 0 = pass clock.
- i2c_write_en  output  1  1 = master drives SDA; 0 = released for slave/ACK.
- ready  output  1  1 when in IDLE and able to accept enable.
- done  output  1  one-cycle pulse on the STOP->IDLE transition.
- ack_error  output  1  sticky NACK flag; cleared on next START.

Behaviour:
- Reset (resetN=1, asynchronous):
  - state=IDLE, count=0, i2c_scl_en=1, i2c_write_en=0.
  - ready=1 once reset is released; done=0, ack_error=0.
  - Reset mid-transaction aborts immediately; no STOP is generated, and the bus is released within the reset.
- All transitions occur on posedge i2c_scl_in.
- IDLE: if enable=1, capture rw and go to START; otherwise stay.
- START: count<=7, ack_error<=0, go to ADDRESS.
- ADDRESS: if count==0 go to READ_ACK, else count<=count-1. This gives 8 cycles (7 address bits plus R/W).
- READ_ACK: sample SDA_in.
  - 1 (NACK): ack_error<=1, go to STOP.
  - 0: count<=7; go to READ_DATA if rw=1, else WRITE_DATA.
- WRITE_DATA: count decrements; at count==0 go to READ_ACK2.
- READ_ACK2: NACK gives ack_error<=1 and STOP. ACK gives STOP, unless burst continues (see Optional Feature).
- READ_DATA: count decrements; at count==0 go to WRITE_ACK2.
- WRITE_ACK2: master NACK, then STOP, unless burst continues.
- STOP: go to IDLE and pulse done=1 for that one cycle.
- Decoded outputs, registered with state:
  - i2c_scl_en=1 in IDLE, START, STOP; 0 elsewhere.
  - i2c_write_en=1 in START, ADDRESS, WRITE_DATA, WRITE_ACK2, STOP; 0 in IDLE, READ_ACK, READ_ACK2, READ_DATA.
- ready=1 only in IDLE.
- Changes to enable or rw outside the sampling states are ignored.
- count never underflows; it is reloaded to 7 on every byte entry.
- Unknown state code: recover to IDLE on the next edge.

Optional Feature:
- Macro I2C_BURST_EN.
- Defined:
  - A 4-bit byte counter increments on each completed data byte.
  - In READ_ACK2 (slave ACK) or WRITE_ACK2: if enable=1 and bytes<BURST_MAX, count<=7 and return to WRITE_DATA or READ_DATA respectively. Otherwise go to STOP.
  - In the burst read case, WRITE_ACK2 is a master ACK; an output ack_bit (0 = ACK) is added for the datapath.
- Undefined:
  - Strictly single-byte transactions.
  - No byte counter and no ack_bit port.

Decomposition:
- Shared package/define file holds the state codes: IDLE, START, ADDRESS, READ_ACK, WRITE_DATA, READ_ACK2, READ_DATA, WRITE_ACK2, STOP, as 8-bit constants.
- The datapath and this block import the same definitions.
- No sub-module: a single FSM with its counter. A separate counter module is not warranted.

Test Plan:
- Reset asserted mid-ADDRESS (count=3) -> state=IDLE, i2c_scl_en=1, i2c_write_en=0 with no clock edge; ready=1 after release.
- Write, rw=0, enable pulse, SDA_in=0 at both ACKs -> sequence IDLE, START, ADDRESS×8 (count 7..0), READ_ACK, WRITE_DATA×8, READ_ACK2, STOP, IDLE; done pulse once; ack_error=0.
- Read, rw=1, ACK -> READ_DATA×8 with i2c_write_en=0, then WRITE_ACK2 with i2c_write_en=1, then STOP; done=1.
- Address NACK, SDA_in=1 in READ_ACK -> next state STOP, ack_error=1 held through IDLE, cleared at the next START.
- rw toggled during WRITE_DATA -> no effect; the transaction completes as a write.
- With I2C_BURST_EN, BURST_MAX=2, enable held high, write -> two WRITE_DATA bytes, then STOP despite enable=1.
